// File: rtl/pulse_length_counter_multi.sv
`default_nettype none
// ============================================================================
// Module   : pulse_length_counter_multi
// Purpose  : NUM_CH independent pulse-length down-counters. Each channel
//            counts a programmable length L and repeats it R extra times.
//            Each channel also supports hold (pause) and abort.
// Ports    :
//   clk             - single clock, all state updates on rising edge
//   rst             - synchronous reset, active-low
//   set[i]          - load strobe: count<=L, rep_left<=R
//   abort[i]        - stop the channel without a done pulse
//   hold[i]         - freeze the channel while high
//   length_in       - packed per-channel length L (LENGTH_WIDTH each)
//   repeat_in       - packed per-channel repeat R (REPEAT_WIDTH each)
//   cur_count_out   - packed per-channel current count
//   rep_left_out    - packed per-channel remaining repeats
//   counter_running - per-channel count != 0 (combinational)
//   period_wrap     - 1-cycle pulse when the count reloads for a new period
//   done            - 1-cycle pulse when the final period completes
//   any_running     - OR of counter_running
// Revision : 1.0 - initial release
// ============================================================================
module pulse_length_counter_multi #(
   parameter int NUM_CH       = 4,
   parameter int LENGTH_WIDTH = 7,
   parameter int REPEAT_WIDTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CH-1:0]                set,
   input  logic [NUM_CH-1:0]                abort,
   input  logic [NUM_CH-1:0]                hold,
   input  logic [NUM_CH*LENGTH_WIDTH-1:0]   length_in,
   input  logic [NUM_CH*REPEAT_WIDTH-1:0]   repeat_in,
   output logic [NUM_CH*LENGTH_WIDTH-1:0]   cur_count_out,
   output logic [NUM_CH*REPEAT_WIDTH-1:0]   rep_left_out,
   output logic [NUM_CH-1:0]                counter_running,
   output logic [NUM_CH-1:0]                period_wrap,
   output logic [NUM_CH-1:0]                done,
   output logic                             any_running
);

   localparam logic [LENGTH_WIDTH-1:0] c_LEN_ZERO = '0;
   localparam logic [LENGTH_WIDTH-1:0] c_LEN_ONE  = LENGTH_WIDTH'(1);
   localparam logic [REPEAT_WIDTH-1:0] c_REP_ZERO = '0;
   localparam logic [REPEAT_WIDTH-1:0] c_REP_ONE  = REPEAT_WIDTH'(1);

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
         logic [LENGTH_WIDTH-1:0] r_count;
         logic [LENGTH_WIDTH-1:0] r_len;
         logic [REPEAT_WIDTH-1:0] r_rep_left;
         logic                    r_wrap;
         logic                    r_done;

         always_ff @(posedge clk) begin
            if (!rst) begin
               r_count    <= c_LEN_ZERO;
               r_len      <= c_LEN_ZERO;
               r_rep_left <= c_REP_ZERO;
               r_wrap     <= 1'b0;
               r_done     <= 1'b0;
            end else if (set[g]) begin
               // A load always restarts cleanly, discarding any run in flight.
               r_count    <= length_in[g*LENGTH_WIDTH +: LENGTH_WIDTH];
               r_len      <= length_in[g*LENGTH_WIDTH +: LENGTH_WIDTH];
               r_rep_left <= repeat_in[g*REPEAT_WIDTH +: REPEAT_WIDTH];
               r_wrap     <= 1'b0;
               r_done     <= 1'b0;
            end else if (abort[g]) begin
               r_count    <= c_LEN_ZERO;
               r_rep_left <= c_REP_ZERO;
               r_wrap     <= 1'b0;
               r_done     <= 1'b0;
            end else if (hold[g]) begin
               r_wrap     <= 1'b0;
               r_done     <= 1'b0;
            end else begin
               r_wrap     <= 1'b0;
               r_done     <= 1'b0;
               if (r_count == c_LEN_ONE) begin
                  // Last cycle of a period: either reload or finish.
                  if (r_rep_left != c_REP_ZERO) begin
                     r_count    <= r_len;
                     r_rep_left <= r_rep_left - c_REP_ONE;
                     r_wrap     <= 1'b1;
                  end else begin
                     r_count    <= c_LEN_ZERO;
                     r_done     <= 1'b1;
                  end
               end else if (r_count != c_LEN_ZERO) begin
                  r_count <= r_count - c_LEN_ONE;
               end
            end
         end

         assign cur_count_out[g*LENGTH_WIDTH +: LENGTH_WIDTH] = r_count;
         assign rep_left_out[g*REPEAT_WIDTH +: REPEAT_WIDTH]  = r_rep_left;
         assign counter_running[g]                            = (r_count != c_LEN_ZERO);
         assign period_wrap[g]                                = r_wrap;
         assign done[g]                                       = r_done;
      end
   endgenerate

   assign any_running = |counter_running;

endmodule
`default_nettype wire

// File: tb/tb_pulse_length_counter_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_length_counter_multi
// Purpose  : Self-checking bench for pulse_length_counter_multi. A reference
//            model pushes the expected outputs on every rising edge. The
//            checker pops and compares them on the falling edge. Directed
//            checks pin down the documented sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_length_counter_multi;

   localparam int NCH = 4;
   localparam int LW  = 7;
   localparam int RW  = 4;

   logic                 clk;
   logic                 rst;
   logic [NCH-1:0]       set;
   logic [NCH-1:0]       abort;
   logic [NCH-1:0]       hold;
   logic [NCH*LW-1:0]    length_in;
   logic [NCH*RW-1:0]    repeat_in;
   logic [NCH*LW-1:0]    cur_count_out;
   logic [NCH*RW-1:0]    rep_left_out;
   logic [NCH-1:0]       counter_running;
   logic [NCH-1:0]       period_wrap;
   logic [NCH-1:0]       done;
   logic                 any_running;

   pulse_length_counter_multi #(
      .NUM_CH       (NCH),
      .LENGTH_WIDTH (LW),
      .REPEAT_WIDTH (RW)
   ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .set             (set),
      .abort           (abort),
      .hold            (hold),
      .length_in       (length_in),
      .repeat_in       (repeat_in),
      .cur_count_out   (cur_count_out),
      .rep_left_out    (rep_left_out),
      .counter_running (counter_running),
      .period_wrap     (period_wrap),
      .done            (done),
      .any_running     (any_running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int r_checks   = 0;
   int r_failures = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      r_checks++;
      if (act !== exp) begin
         r_failures++;
         $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic [NCH*LW-1:0] cnt;
      logic [NCH*RW-1:0] rep;
      logic [NCH-1:0]    run;
      logic [NCH-1:0]    wrap;
      logic [NCH-1:0]    dn;
      logic              any;
   } exp_t;

   exp_t      sb_q[$];
   int        m_cnt  [NCH];
   int        m_len  [NCH];
   int        m_rep  [NCH];
   bit        m_wrap [NCH];
   bit        m_done [NCH];

   always @(posedge clk) begin
      exp_t e;
      for (int c = 0; c < NCH; c++) begin
         if (!rst) begin
            m_cnt[c] = 0; m_len[c] = 0; m_rep[c] = 0; m_wrap[c] = 0; m_done[c] = 0;
         end else if (set[c]) begin
            m_len[c]  = int'(length_in[c*LW +: LW]);
            m_cnt[c]  = m_len[c];
            m_rep[c]  = int'(repeat_in[c*RW +: RW]);
            m_wrap[c] = 0; m_done[c] = 0;
         end else if (abort[c]) begin
            m_cnt[c] = 0; m_rep[c] = 0; m_wrap[c] = 0; m_done[c] = 0;
         end else begin
            m_wrap[c] = 0; m_done[c] = 0;
            if (!hold[c] && m_cnt[c] > 0) begin
               m_cnt[c] = m_cnt[c] - 1;
               if (m_cnt[c] == 0 && m_rep[c] > 0) begin
                  m_rep[c]  = m_rep[c] - 1;
                  m_cnt[c]  = m_len[c];
                  m_wrap[c] = 1;
               end else if (m_cnt[c] == 0) begin
                  m_done[c] = 1;
               end
            end
         end
      end
      e = '0;
      for (int c = 0; c < NCH; c++) begin
         e.cnt[c*LW +: LW] = LW'(m_cnt[c]);
         e.rep[c*RW +: RW] = RW'(m_rep[c]);
         e.run[c]          = (m_cnt[c] != 0);
         e.wrap[c]         = m_wrap[c];
         e.dn[c]           = m_done[c];
      end
      e.any = |e.run;
      sb_q.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         for (int c = 0; c < NCH; c++) begin
            check($sformatf("sb_cnt%0d", c),  32'(cur_count_out[c*LW +: LW]), 32'(e.cnt[c*LW +: LW]));
            check($sformatf("sb_rep%0d", c),  32'(rep_left_out[c*RW +: RW]),  32'(e.rep[c*RW +: RW]));
            check($sformatf("sb_run%0d", c),  32'(counter_running[c]),        32'(e.run[c]));
            check($sformatf("sb_wrap%0d", c), 32'(period_wrap[c]),            32'(e.wrap[c]));
            check($sformatf("sb_done%0d", c), 32'(done[c]),                   32'(e.dn[c]));
         end
         check("sb_any", 32'(any_running), 32'(e.any));
      end
   end

   // ---------------- stimulus helpers ----------------
   // Inputs change 2 time units after a rising edge, well clear of sampling.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic load(input int c, input int l, input int r);
      length_in[c*LW +: LW] = LW'(l);
      repeat_in[c*RW +: RW] = RW'(r);
      set[c] = 1'b1;
   endtask

   function automatic int cnt_of(input int c);
      return int'(cur_count_out[c*LW +: LW]);
   endfunction

   // ---------------- directed scenarios ----------------
   initial begin
      rst = 1'b0; set = '0; abort = '0; hold = '0; length_in = '0; repeat_in = '0;
      step(2);
      check("rst_cnt", 32'(cur_count_out), 32'd0);
      check("rst_any", 32'(any_running), 32'd0);
      rst = 1'b1;
      step(1);

      // ch0 L=3 R=0: 3,2,1,0 with done only at the 0 cycle
      load(0, 3, 0); step(1); set = '0;
      check("c0_t1", 32'(cnt_of(0)), 32'd3);
      check("c0_run", 32'(counter_running[0]), 32'd1);
      step(2);
      check("c0_t3", 32'(cnt_of(0)), 32'd1);
      check("c0_nodone", 32'(done[0]), 32'd0);
      step(1);
      check("c0_t4", 32'(cnt_of(0)), 32'd0);
      check("c0_done", 32'(done[0]), 32'd1);
      step(1);
      check("c0_done_clr", 32'(done[0]), 32'd0);

      // ch1 L=2 R=2: wrap at t+3 and t+5, done at t+7
      load(1, 2, 2); step(1); set = '0;
      step(2);
      check("c1_wrap1", 32'(period_wrap[1]), 32'd1);
      check("c1_cnt3", 32'(cnt_of(1)), 32'd2);
      check("c1_rep3", 32'(rep_left_out[1*RW +: RW]), 32'd1);
      step(4);
      check("c1_done", 32'(done[1]), 32'd1);

      // ch2 L=4: hold two cycles at count 3 -> 4,3,3,3,2,1,0
      load(2, 4, 0); step(1); set = '0;
      step(1);
      hold[2] = 1'b1; step(2); hold[2] = 1'b0;
      check("c2_held", 32'(cnt_of(2)), 32'd3);
      step(3);
      check("c2_done", 32'(done[2]), 32'd1);

      // ch3 L=5 R=1: abort at count 2, then L=0 load stays idle
      load(3, 5, 1); step(1); set = '0;
      step(3);
      check("c3_at2", 32'(cnt_of(3)), 32'd2);
      abort[3] = 1'b1; step(1); abort[3] = 1'b0;
      check("c3_abort", 32'(cnt_of(3)), 32'd0);
      check("c3_nodone", 32'(done[3]), 32'd0);
      load(3, 0, 3); step(1); set = '0;
      check("c3_l0_run", 32'(counter_running[3]), 32'd0);
      step(2);

      // ch0 L=6 re-set to L=2 at count 4 while ch1 runs
      load(0, 6, 0); load(1, 3, 1); step(1); set = '0;
      step(2);
      check("c0_at4", 32'(cnt_of(0)), 32'd4);
      load(0, 2, 0); step(1); set = '0;
      check("c0_reset_run", 32'(cnt_of(0)), 32'd2);
      step(2);
      check("c0_single_done", 32'(done[0]), 32'd1);
      step(4);

      // L=1 with repeats: wrap every cycle
      load(2, 1, 3); step(1); set = '0;
      step(1);
      check("c2_l1_wrap", 32'(period_wrap[2]), 32'd1);
      step(4);

      // all running, reset for one cycle
      for (int c = 0; c < NCH; c++) load(c, 10, 2);
      step(1); set = '0;
      step(3);
      rst = 1'b0; step(1); rst = 1'b1;
      check("mid_rst_cnt", 32'(cur_count_out), 32'd0);
      check("mid_rst_any", 32'(any_running), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);

      // random traffic checked by the scoreboard
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < NCH; c++) begin
            set[c]   = ($urandom_range(0, 15) == 0);
            abort[c] = ($urandom_range(0, 40) == 0);
            hold[c]  = ($urandom_range(0, 6) == 0);
            length_in[c*LW +: LW] = LW'($urandom_range(0, 6));
            repeat_in[c*RW +: RW] = RW'($urandom_range(0, 3));
         end
         rst = ($urandom_range(0, 150) != 0);
         step(1);
      end
      set = '0; abort = '0; hold = '0; rst = 1'b1;
      step(40);
      @(negedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
      $finish;
   end

endmodule
`default_nettype wire
